// File: rtl/cache.sv
// cache: direct-mapped, write-back data cache between the CPU-side RAMIO
// decoder and a 64-bit, 4-beat burst RAM controller (one 32-byte line per
// burst command).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                request valid
//   address[31:0]         byte address ([1:0] ignored, high bits alias)
//   data_in[31:0]         write data, byte-lane aligned
//   write_enable[3:0]     per-byte write strobe, 0 = read
//   data_out[31:0]        selected word of the indexed line (combinational)
//   data_out_ready        request hits and the fill FSM is idle
//   busy                  request cannot complete this cycle
//   br_cmd                burst command: 0 = read, 1 = write
//   br_cmd_en             one-cycle command strobe
//   br_addr               line start address in RAM units
//   br_wr_data[63:0]      write-burst beat
//   br_data_mask[7:0]     always 0
//   br_rd_data[63:0]      read-burst beat
//   br_rd_data_valid      qualifies br_rd_data
module cache #(
  parameter int LINE_IX_BITWIDTH    = 1,
  parameter int RAM_DEPTH_BITWIDTH  = 10,
  parameter int RAM_ADDRESSING_MODE = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [31:0]                   address,
  input  logic [31:0]                   data_in,
  input  logic [3:0]                    write_enable,
  output logic [31:0]                   data_out,
  output logic                          data_out_ready,
  output logic                          busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
);
  localparam int LINES  = 1 << LINE_IX_BITWIDTH;
  localparam int TAG_W  = RAM_DEPTH_BITWIDTH + RAM_ADDRESSING_MODE - 5 - LINE_IX_BITWIDTH;
  localparam int TAG_LO = 5 + LINE_IX_BITWIDTH;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;
  localparam int LBA_W  = RAM_DEPTH_BITWIDTH + RAM_ADDRESSING_MODE;

  typedef enum logic [1:0] {IDLE, WB, RD, RD_WAIT} state_t;

  logic [31:0]                 mem  [LINES][8];
  logic [TAG_W-1:0]            tags [LINES];
  logic [LINES-1:0]            valid, dirty;
  state_t                      state;
  logic [1:0]                  beat, nbeat;
  logic [LINE_IX_BITWIDTH-1:0] fill_ix;
  logic [TAG_W-1:0]            fill_tag;

  logic [LINE_IX_BITWIDTH-1:0] ix;
  logic [TAG_W-1:0]            tag;
  logic [2:0]                  word;
  logic                        hit, is_idle, wr_hit, fill_we, fill_done;
  logic                        unused_addr;

  assign ix    = address[TAG_LO-1:5];
  assign tag   = address[TAG_HI:TAG_LO];
  assign word  = address[4:2];
  assign nbeat = beat + 2'd1;
  assign unused_addr = ^{address[1:0], address[31:TAG_HI+1]};

  assign hit            = enable && valid[ix] && (tags[ix] == tag);
  assign is_idle        = (state == IDLE);
  assign data_out_ready = hit && is_idle;
  assign busy           = enable && (!hit || !is_idle);
  assign data_out       = mem[ix][word];
  assign br_data_mask   = '0;

  assign wr_hit    = data_out_ready && (write_enable != 4'd0);
  assign fill_we   = (state == RD_WAIT) && br_rd_data_valid;
  assign fill_done = fill_we && (beat == 2'd3);

  // Line start in RAM units: {tag, ix, 5'b0} >> RAM_ADDRESSING_MODE.
  function automatic logic [RAM_DEPTH_BITWIDTH-1:0] line_addr(
    input logic [TAG_W-1:0] t, input logic [LINE_IX_BITWIDTH-1:0] i);
    logic [LBA_W-1:0] lba;
    lba = {t, i, 5'b0};
    return lba[LBA_W-1:RAM_ADDRESSING_MODE];
  endfunction

  // Line data and tags carry no reset; the valid bits qualify them.
  // Write hits only happen in IDLE and fills only outside it, so the two
  // write ports never collide.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      for (int b = 0; b < 4; b++)
        if (write_enable[b]) mem[ix][word][8*b +: 8] <= data_in[8*b +: 8];
    end
    if (fill_we) begin
      mem[fill_ix][{beat, 1'b0}] <= br_rd_data[31:0];
      mem[fill_ix][{beat, 1'b1}] <= br_rd_data[63:32];
    end
    if (fill_done) tags[fill_ix] <= fill_tag;
  end

  // Fill FSM. Bus outputs are registered, so the command strobe is visible
  // during the first cycle of WB (write) or RD (read). The target line is
  // latched at the miss so a changed request cannot redirect a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= 2'd0;
      valid      <= '0;
      dirty      <= '0;
      fill_ix    <= '0;
      fill_tag   <= '0;
      br_cmd     <= 1'b0;
      br_cmd_en  <= 1'b0;
      br_addr    <= '0;
      br_wr_data <= '0;
    end else begin
      br_cmd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hit) begin
            dirty[ix] <= 1'b1;
          end else if (enable && !hit) begin
            fill_ix   <= ix;
            fill_tag  <= tag;
            beat      <= 2'd0;
            br_cmd_en <= 1'b1;
            if (valid[ix] && dirty[ix]) begin
              state      <= WB;
              br_cmd     <= 1'b1;
              br_addr    <= line_addr(tags[ix], ix);
              br_wr_data <= {mem[ix][1], mem[ix][0]};
            end else begin
              state   <= RD;
              br_cmd  <= 1'b0;
              br_addr <= line_addr(tag, ix);
            end
          end
        end
        WB: begin
          if (beat == 2'd3) begin
            state     <= RD;
            beat      <= 2'd0;
            br_cmd_en <= 1'b1;
            br_cmd    <= 1'b0;
            br_addr   <= line_addr(fill_tag, fill_ix);
          end else begin
            beat       <= nbeat;
            br_wr_data <= {mem[fill_ix][{nbeat, 1'b1}], mem[fill_ix][{nbeat, 1'b0}]};
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          if (br_rd_data_valid) begin
            beat <= nbeat;
            if (beat == 2'd3) begin
              valid[fill_ix] <= 1'b1;
              dirty[fill_ix] <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache.sv
// Directed self-checking bench for cache (default parameters: 2 lines,
// 7-bit tag, 64-bit RAM units). Inputs change on the falling edge,
// outputs are sampled 1 ns later.
module tb_cache;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] address, data_in, data_out;
  logic [3:0]  write_enable;
  logic        data_out_ready, busy, br_cmd, br_cmd_en, br_rd_data_valid;
  logic [9:0]  br_addr;
  logic [63:0] br_wr_data, br_rd_data;
  logic [7:0]  br_data_mask;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc;

  cache dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .address(address),
    .data_in(data_in), .write_enable(write_enable), .data_out(data_out),
    .data_out_ready(data_out_ready), .busy(busy), .br_cmd(br_cmd),
    .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    enable = 1'b1; address = a; write_enable = we; data_in = d;
  endtask

  // Wait (bounded) for the next command strobe; cycles counted from the
  // falling edge where the request was applied.
  task automatic wait_cmd(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!br_cmd_en && n < 20);
    #1;
    chk("cmd_seen", br_cmd_en, 1'b1);
  endtask

  // Return a line; word n = base + n*step. Optional idle cycle after beat gap_after.
  task automatic feed(input logic [31:0] base, input logic [31:0] step, input int gap_after);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      br_rd_data_valid = 1'b1;
      br_rd_data = {base + (2*k+1)*step, base + (2*k)*step};
      if (k == gap_after) begin
        @(negedge clk);
        br_rd_data_valid = 1'b0;
      end
    end
    @(negedge clk);
    br_rd_data_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; address = '0; data_in = '0; write_enable = '0;
    br_rd_data = '0; br_rd_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", data_out_ready, 1'b0);
    chk("rst_cmd_en", br_cmd_en, 1'b0);
    chk("rst_addr", br_addr, 10'h0);
    chk("rst_wr_data", br_wr_data, 64'h0);
    chk("mask", br_data_mask, 8'h0);
    @(negedge clk); rst_n = 1'b1;

    // Clean miss on an invalid line, word 4; gap between beats 1 and 2.
    @(negedge clk); drive(32'h10, 4'h0, 0); #1;
    chk("miss_busy", busy, 1'b1);
    chk("miss_ready", data_out_ready, 1'b0);
    wait_cmd(cyc);
    chk("miss_latency", cyc, 1);
    chk("miss_cmd", br_cmd, 1'b0);
    chk("miss_addr", br_addr, 10'h000);   // line-aligned start of 0x10
    feed(32'h0, 32'h1111_1111, 1);
    chk("fill_ready", data_out_ready, 1'b1);
    chk("fill_busy", busy, 1'b0);
    chk("fill_data", data_out, 32'h4444_4444);

    // Read hit on the same line: no new command.
    @(negedge clk); drive(32'h1C, 4'h0, 0); #1;
    chk("hit_ready", data_out_ready, 1'b1);
    chk("hit_busy", busy, 1'b0);
    chk("hit_data", data_out, 32'h7777_7777);
    @(negedge clk); #1;
    chk("hit_no_cmd", br_cmd_en, 1'b0);

    // Full-word write, then byte-lane merge.
    @(negedge clk); drive(32'h08, 4'hF, 32'h1234_5678); #1;
    chk("wr_ready", data_out_ready, 1'b1);
    @(negedge clk); drive(32'h08, 4'h0, 0); #1;
    chk("wr_word", data_out, 32'h1234_5678);
    @(negedge clk); drive(32'h08, 4'b0100, 32'h00AB_0000); #1;
    chk("wr_byte_busy", busy, 1'b0);
    @(negedge clk); drive(32'h08, 4'h0, 0); #1;
    chk("wr_byte", data_out, 32'h12AB_5678);

    // Dirty eviction: same index, tag 1.
    @(negedge clk); drive(32'h40, 4'h0, 0);
    wait_cmd(cyc);
    chk("wb_latency", cyc, 1);
    chk("wb_cmd", br_cmd, 1'b1);
    chk("wb_addr", br_addr, 10'h000);
    chk("wb_beat0", br_wr_data, 64'h1111_1111_0000_0000);
    @(negedge clk); #1;
    chk("wb_strobe_once", br_cmd_en, 1'b0);
    chk("wb_beat1", br_wr_data, 64'h3333_3333_12AB_5678);
    @(negedge clk); #1;
    chk("wb_beat2", br_wr_data, 64'h5555_5555_4444_4444);
    @(negedge clk); #1;
    chk("wb_beat3", br_wr_data, 64'h7777_7777_6666_6666);
    wait_cmd(cyc);
    chk("wb_rd_latency", cyc, 1);
    chk("wb_rd_cmd", br_cmd, 1'b0);
    chk("wb_rd_addr", br_addr, 10'h008);
    feed(32'hA000_0000, 32'h1, -1);
    chk("evict_data", data_out, 32'hA000_0000);

    // Write miss on invalid line 1: fetch, then merge byte 0.
    @(negedge clk); drive(32'h24, 4'b0001, 32'h0000_00CD);
    wait_cmd(cyc);
    chk("wm_cmd", br_cmd, 1'b0);
    chk("wm_addr", br_addr, 10'h004);
    feed(32'hB000_0000, 32'h1, -1);
    chk("wm_ready", data_out_ready, 1'b1);
    @(negedge clk); drive(32'h24, 4'h0, 0); #1;
    chk("wm_merge", data_out, 32'hB000_00CD);

    // Write miss with a clean valid victim (line 0 holds tag 1): no write-back.
    @(negedge clk); drive(32'h00, 4'b1000, 32'hEE00_0000);
    wait_cmd(cyc);
    chk("cv_cmd", br_cmd, 1'b0);
    chk("cv_addr", br_addr, 10'h000);
    feed(32'hC0C0_C0C0, 32'h1, 2);
    @(negedge clk); drive(32'h00, 4'h0, 0); #1;
    chk("cv_merge", data_out, 32'hEEC0_C0C0);

    // Reset in RD_WAIT (line 0 now dirty, so a write-back precedes the read).
    @(negedge clk); drive(32'h80, 4'h0, 0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(br_cmd_en && !br_cmd) && cyc < 20);
    chk("rr_rd_seen", br_cmd_en && !br_cmd, 1'b1);
    chk("rr_rd_addr", br_addr, 10'h010);
    @(negedge clk); br_rd_data_valid = 1'b1; br_rd_data = 64'h1;
    @(negedge clk); br_rd_data = 64'h2;
    @(negedge clk); br_rd_data_valid = 1'b0; rst_n = 1'b0; #1;
    chk("rr_cmd_en", br_cmd_en, 1'b0);
    chk("rr_addr", br_addr, 10'h0);
    chk("rr_busy", busy, 1'b1);
    @(negedge clk); enable = 1'b0; rst_n = 1'b1;
    // Line 0 tag 0 was valid before reset; now it must miss without write-back.
    @(negedge clk); drive(32'h00, 4'h0, 0); #1;
    chk("post_rst_busy", busy, 1'b1);
    chk("post_rst_ready", data_out_ready, 1'b0);
    wait_cmd(cyc);
    chk("post_rst_cmd", br_cmd, 1'b0);
    chk("post_rst_addr", br_addr, 10'h000);
    feed(32'hD000_0000, 32'h1, -1);
    chk("post_rst_data", data_out, 32'hD000_0000);

    @(negedge clk); enable = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
